// File: rtl/dac_frame_scheduler.sv
// dac_frame_scheduler
// Builds the single 16-bit frame stream for the DAC7811 serializer. It merges two sources:
// - periodic waveform samples, read from an external 1-cycle-latency ROM;
// - host control commands, buffered in a small FIFO.
// The scheduler owns the ROM address counter, the sample timer and the arbitration.
module dac_frame_scheduler #(
    parameter int WAVE_LEN  = 1250,
    parameter int ADDR_W    = 11,
    parameter int DIV       = 20,
    parameter int CMD_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ENABLE,
    output logic [ADDR_W-1:0] ROM_ADDR,
    input  logic [11:0]       ROM_DATA,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [3:0]        CMD_CODE,
    input  logic [11:0]       CMD_DATA,
    output logic [15:0]       FRAME,
    output logic              FRAME_VALID,
    input  logic              FRAME_READY,
    output logic              SAMPLE_MISS,
    output logic [15:0]       MISS_COUNT,
    output logic              CMD_ERR
);

    localparam int TMR_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(WAVE_LEN - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(CMD_DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(CMD_DEPTH);

    // Control code carried by every waveform sample frame (write-and-load).
    localparam logic [3:0] SAMPLE_CODE = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND_SAMPLE,
        ST_SEND_CMD
    } state_t;

    // Host commands accepted into the FIFO. Code 0001 is reserved for samples.
    function automatic logic f_code_legal(input logic [3:0] code);
        logic ok;
        case (code)
            4'b0000, 4'b0010, 4'b1001, 4'b1010, 4'b1011, 4'b1100: ok = 1'b1;
            default:                                              ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] f_sat_inc(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;

    logic [TMR_W-1:0]   r_timer;
    logic               w_sample_due;

    logic [ADDR_W-1:0]  r_rom_addr;

    logic               r_buf_full;
    logic [15:0]        r_buf_frame;
    logic               w_buf_accept;
    logic               w_sample_lost;

    logic               r_sample_miss;
    logic [15:0]        r_miss_count;

    logic [15:0]        r_fifo_mem [CMD_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_fifo_cnt;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_cmd_push;
    logic               w_cmd_legal;
    logic               w_fifo_wr;
    logic               w_fifo_rd;

    logic               r_cmd_err;

    logic [15:0]        r_frame;
    logic               w_load_sample;
    logic               w_load_cmd;
    logic               w_sample_done;

    // A sample slot opens on the last timer count. The slot only exists while ENABLE is high.
    assign w_sample_due = ENABLE && (r_timer == TMR_LAST);

    // A frame completes when the serializer accepts it.
    // Completing a sample frame frees the buffer in the same cycle.
    assign w_sample_done = (r_state == ST_SEND_SAMPLE) && FRAME_READY;
    assign w_fifo_rd     = (r_state == ST_SEND_CMD) && FRAME_READY;

    // A due sample is taken if the buffer is empty or is being emptied now.
    // Otherwise the sample is lost.
    assign w_buf_accept  = w_sample_due && (!r_buf_full || w_sample_done);
    assign w_sample_lost = w_sample_due && !w_buf_accept;

    assign w_fifo_full   = (r_fifo_cnt == CNT_FULL);
    assign w_fifo_empty  = (r_fifo_cnt == '0);
    assign w_cmd_push    = CMD_VALID && !w_fifo_full;
    assign w_cmd_legal   = f_code_legal(CMD_CODE);
    assign w_fifo_wr     = w_cmd_push && w_cmd_legal;

    // Sample timer: free-runs 0..DIV-1 while enabled, parked at zero otherwise.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_timer <= '0;
        end else if (!ENABLE || (r_timer == TMR_LAST)) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TMR_W'(1);
        end
    end

    // ROM address: advances once per sample slot, even for a lost slot, so the waveform phase holds.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rom_addr <= '0;
        end else if (w_sample_due) begin
            r_rom_addr <= (r_rom_addr == ADDR_LAST) ? '0 : r_rom_addr + ADDR_W'(1);
        end
    end

    // Sample buffer occupancy: set when a sample is captured, cleared when its frame is sent.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_buf_full <= 1'b0;
        end else if (w_buf_accept) begin
            r_buf_full <= 1'b1;
        end else if (w_sample_done) begin
            r_buf_full <= 1'b0;
        end
    end

    // Sample buffer payload. ROM_DATA already belongs to the current ROM_ADDR.
    always_ff @(posedge CLK) begin
        if (w_buf_accept) begin
            r_buf_frame <= {SAMPLE_CODE, ROM_DATA};
        end
    end

    // Lost-sample pulse and saturating lost-sample counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sample_miss <= 1'b0;
            r_miss_count  <= '0;
        end else begin
            r_sample_miss <= w_sample_lost;
            if (w_sample_lost) begin
                r_miss_count <= f_sat_inc(r_miss_count);
            end
        end
    end

    // Command FIFO storage. Only legal codes are written.
    always_ff @(posedge CLK) begin
        if (w_fifo_wr) begin
            r_fifo_mem[r_wr_ptr] <= {CMD_CODE, CMD_DATA};
        end
    end

    // Command FIFO pointers and occupancy. A push and a pop in the same cycle cancel out.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_fifo_wr) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_fifo_rd) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_fifo_wr, w_fifo_rd})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // Illegal-command pulse. The handshake itself still completes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cmd_err <= 1'b0;
        end else begin
            r_cmd_err <= w_cmd_push && !w_cmd_legal;
        end
    end

    // Arbiter state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Arbiter next state. Samples win over commands in IDLE.
    // A frame that is already valid runs to completion.
    // Returning to IDLE after each transfer leaves a gap cycle between frames.
    always_comb begin
        w_state_nxt   = r_state;
        w_load_sample = 1'b0;
        w_load_cmd    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_buf_full) begin
                    w_state_nxt   = ST_SEND_SAMPLE;
                    w_load_sample = 1'b1;
                end else if (!w_fifo_empty) begin
                    w_state_nxt = ST_SEND_CMD;
                    w_load_cmd  = 1'b1;
                end
            end
            ST_SEND_SAMPLE: begin
                if (FRAME_READY) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SEND_CMD: begin
                if (FRAME_READY) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output frame register. It is loaded only when a frame starts, so it stays stable while stalled.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_frame <= '0;
        end else if (w_load_sample) begin
            r_frame <= r_buf_frame;
        end else if (w_load_cmd) begin
            r_frame <= r_fifo_mem[r_rd_ptr];
        end
    end

    assign ROM_ADDR    = r_rom_addr;
    assign CMD_READY   = !w_fifo_full;
    assign FRAME       = r_frame;
    assign FRAME_VALID = (r_state != ST_IDLE);
    assign SAMPLE_MISS = r_sample_miss;
    assign MISS_COUNT  = r_miss_count;
    assign CMD_ERR     = r_cmd_err;

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// tb_dac_frame_scheduler
// Directed scenarios followed by a randomized phase.
// All outputs are compared every cycle against a queue-based reference model of the frame scheduler.
module tb_dac_frame_scheduler;

    localparam int WAVE_LEN  = 1250;
    localparam int ADDR_W    = 11;
    localparam int DIV       = 20;
    localparam int CMD_DEPTH = 4;

    logic              CLK = 1'b0;
    logic              RST;
    logic              ENABLE;
    logic [ADDR_W-1:0] ROM_ADDR;
    logic [11:0]       ROM_DATA;
    logic              CMD_VALID;
    logic              CMD_READY;
    logic [3:0]        CMD_CODE;
    logic [11:0]       CMD_DATA;
    logic [15:0]       FRAME;
    logic              FRAME_VALID;
    logic              FRAME_READY;
    logic              SAMPLE_MISS;
    logic [15:0]       MISS_COUNT;
    logic              CMD_ERR;

    dac_frame_scheduler #(
        .WAVE_LEN (WAVE_LEN),
        .ADDR_W   (ADDR_W),
        .DIV      (DIV),
        .CMD_DEPTH(CMD_DEPTH)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ENABLE     (ENABLE),
        .ROM_ADDR   (ROM_ADDR),
        .ROM_DATA   (ROM_DATA),
        .CMD_VALID  (CMD_VALID),
        .CMD_READY  (CMD_READY),
        .CMD_CODE   (CMD_CODE),
        .CMD_DATA   (CMD_DATA),
        .FRAME      (FRAME),
        .FRAME_VALID(FRAME_VALID),
        .FRAME_READY(FRAME_READY),
        .SAMPLE_MISS(SAMPLE_MISS),
        .MISS_COUNT (MISS_COUNT),
        .CMD_ERR    (CMD_ERR)
    );

    always #5 CLK = ~CLK;

    // Synchronous sample ROM with one cycle of read latency.
    logic [11:0] rom [WAVE_LEN];
    always @(posedge CLK) ROM_DATA <= rom[ROM_ADDR];

    // Reference model state.
    int          m_timer;
    int          m_addr;
    logic [15:0] m_buf[$];
    logic [15:0] m_fifo[$];
    bit          m_valid;
    bit          m_is_sample;
    logic [15:0] m_frame;
    bit          m_miss;
    bit          m_err;
    int          m_miss_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          dut_xfers = 0;
    int          err_pulses = 0;
    logic [15:0] last_frame = '0;

    logic [3:0]  legal_codes [6] = '{4'h0, 4'h2, 4'h9, 4'hA, 4'hB, 4'hC};

    function automatic bit is_legal(input logic [3:0] c);
        foreach (legal_codes[i]) if (legal_codes[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_timer = 0; m_addr = 0;
        m_buf.delete(); m_fifo.delete();
        m_valid = 0; m_is_sample = 0; m_frame = '0;
        m_miss = 0; m_err = 0; m_miss_cnt = 0;
    endtask

    // Advance the model by one clock edge, using the inputs the DUT sees at that edge.
    task automatic model_edge();
        bit          due;
        int          fifo_pre;
        logic [15:0] tmp;
        if (RST) begin
            model_reset();
            return;
        end
        due      = ENABLE && (m_timer == DIV - 1);
        fifo_pre = m_fifo.size();
        // Frame line: finish the current frame, or start the highest-priority waiting one.
        if (m_valid && FRAME_READY) begin
            if (m_is_sample) tmp = m_buf.pop_front();
            else             tmp = m_fifo.pop_front();
            m_valid = 0;
        end else if (!m_valid) begin
            if (m_buf.size() > 0) begin
                m_valid = 1; m_is_sample = 1; m_frame = m_buf[0];
            end else if (fifo_pre > 0) begin
                m_valid = 1; m_is_sample = 0; m_frame = m_fifo[0];
            end
        end
        // Sample slot.
        m_miss = 0;
        if (due) begin
            if (m_buf.size() == 0) m_buf.push_back({4'b0001, rom[m_addr]});
            else begin
                m_miss = 1;
                if (m_miss_cnt < 65535) m_miss_cnt++;
            end
            m_addr = (m_addr + 1) % WAVE_LEN;
        end
        m_timer = ENABLE ? (m_timer + 1) % DIV : 0;
        // Command push.
        m_err = 0;
        if (CMD_VALID && fifo_pre < CMD_DEPTH) begin
            if (is_legal(CMD_CODE)) m_fifo.push_back({CMD_CODE, CMD_DATA});
            else                    m_err = 1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        if (FRAME_VALID === 1'b1 && FRAME_READY) begin
            dut_xfers++;
            last_frame = FRAME;
        end
        @(posedge CLK);
        model_edge();
        #1;
        check("FRAME_VALID", FRAME_VALID, m_valid);
        if (m_valid) check("FRAME", FRAME, m_frame);
        check("ROM_ADDR", ROM_ADDR, m_addr);
        check("SAMPLE_MISS", SAMPLE_MISS, m_miss);
        check("MISS_COUNT", MISS_COUNT, m_miss_cnt);
        check("CMD_ERR", CMD_ERR, m_err);
        check("CMD_READY", CMD_READY, (m_fifo.size() < CMD_DEPTH));
        if (CMD_ERR === 1'b1) err_pulses++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_FRAME"},       FRAME,       16'h0000);
        check({tag, "_FRAME_VALID"}, FRAME_VALID, 1'b0);
        check({tag, "_ROM_ADDR"},    ROM_ADDR,    '0);
        check({tag, "_CMD_READY"},   CMD_READY,   1'b1);
        check({tag, "_SAMPLE_MISS"}, SAMPLE_MISS, 1'b0);
        check({tag, "_MISS_COUNT"},  MISS_COUNT,  16'h0000);
        check({tag, "_CMD_ERR"},     CMD_ERR,     1'b0);
    endtask

    // Offer one command and hold it until the DUT accepts it, with a bounded wait.
    task automatic push_cmd(input logic [3:0] c, input logic [11:0] d);
        bit hs;
        int w;
        hs = 0;
        w  = 0;
        CMD_VALID = 1'b1; CMD_CODE = c; CMD_DATA = d;
        while (!hs && w < 50) begin
            hs = (CMD_READY === 1'b1);
            step();
            w++;
        end
        CMD_VALID = 1'b0;
        check("PUSH_ACCEPTED", hs, 1'b1);
    endtask

    initial begin
        int base_x, base_e, w;
        logic [15:0] miss_before;
        for (int i = 0; i < WAVE_LEN; i++) rom[i] = 12'(i);
        RST = 1'b1; ENABLE = 1'b0; CMD_VALID = 1'b0; CMD_CODE = '0; CMD_DATA = '0;
        FRAME_READY = 1'b1;
        model_reset();
        steps(3);
        check_reset_values("RESET");
        RST = 1'b0;

        // Continuous waveform with ROM_DATA equal to the address: frames 1000, 1001, ...
        ENABLE = 1'b1;
        dut_xfers = 0;
        steps(WAVE_LEN * DIV + 5);
        check("T1_FRAME_COUNT", dut_xfers, WAVE_LEN);
        check("T1_LAST_FRAME", last_frame, {4'b0001, 12'(WAVE_LEN - 1)});
        check("T1_ADDR_WRAP", ROM_ADDR, '0);

        // A single legal command while the waveform is off.
        ENABLE = 1'b0;
        steps(3);
        base_x = dut_xfers; base_e = err_pulses;
        push_cmd(4'b1011, 12'h000);
        steps(6);
        check("T2_ONE_FRAME", dut_xfers - base_x, 1);
        check("T2_FRAME", last_frame, 16'hB000);
        check("T2_NO_ERR", err_pulses - base_e, 0);

        // Illegal codes are accepted and dropped, with one error pulse each.
        base_x = dut_xfers; base_e = err_pulses;
        push_cmd(4'b0001, 12'h123);
        push_cmd(4'b0111, 12'h456);
        steps(6);
        check("T3_ERR_PULSES", err_pulses - base_e, 2);
        check("T3_NO_FRAMES", dut_xfers - base_x, 0);

        // Serializer stalled for 45 cycles while samples keep arriving.
        miss_before = MISS_COUNT;
        ENABLE = 1'b1; FRAME_READY = 1'b0;
        steps(45);
        check("T4_MISS_RANGE", (MISS_COUNT - miss_before >= 1) && (MISS_COUNT - miss_before <= 2), 1'b1);
        FRAME_READY = 1'b1;
        steps(50);

        // Fill the command FIFO while the serializer is stalled.
        ENABLE = 1'b0;
        steps(30);
        FRAME_READY = 1'b0;
        base_x = dut_xfers;
        push_cmd(4'h0, 12'h111);
        push_cmd(4'h2, 12'h222);
        push_cmd(4'h9, 12'h333);
        push_cmd(4'hC, 12'h444);
        check("T5_READY_LOW", CMD_READY, 1'b0);
        CMD_VALID = 1'b1; CMD_CODE = 4'hA; CMD_DATA = 12'h555;
        steps(3);
        CMD_VALID = 1'b0;
        FRAME_READY = 1'b1;
        steps(20);
        check("T5_FOUR_FRAMES", dut_xfers - base_x, 4);
        check("T5_LAST_FRAME", last_frame, 16'hC444);

        // Reset in the middle of a frame.
        ENABLE = 1'b1; FRAME_READY = 1'b0;
        w = 0;
        while (FRAME_VALID !== 1'b1 && w < 60) begin step(); w++; end
        check("T6_VALID_SEEN", FRAME_VALID, 1'b1);
        RST = 1'b1;
        step();
        check_reset_values("T6_MIDFRAME_RST");
        RST = 1'b0; ENABLE = 1'b0; FRAME_READY = 1'b1;
        steps(2);

        // Randomized traffic over random ROM contents.
        for (int i = 0; i < WAVE_LEN; i++) rom[i] = 12'($urandom);
        steps(3);
        for (int cyc = 0; cyc < 8000; cyc++) begin
            if ($urandom_range(0, 49) == 0) ENABLE = ~ENABLE;
            FRAME_READY = ($urandom_range(0, 3) != 0);
            CMD_VALID   = ($urandom_range(0, 5) == 0);
            CMD_CODE    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : legal_codes[$urandom_range(0, 5)];
            CMD_DATA    = 12'($urandom);
            RST         = ($urandom_range(0, 2999) == 0);
            step();
        end
        RST = 1'b0; CMD_VALID = 1'b0;
        steps(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
